char_ram_sequencer: RTL and testbench
=====================================

# char_ram_sequencer

Hardware clear and scroll engine for the 80x30 text-mode character/attribute RAM. It sequences bulk writes over the RAM's single CPU-side access port and arbitrates that port between the engine and the CPU-side Wishbone slave. It sits between the Wishbone text slave and the character/attribute RAM arrays; the video readout port is not touched. Firmware no longer needs to write 2400 spaces to clear or scroll the screen.

## Interface
- COLS, 80, characters per row
- ROWS, 30, rows per screen; DEPTH = COLS*ROWS cells
- AW, 12, RAM address width; DEPTH must be ≤ 2^AW
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle, able to accept a command
- cmd_op  in  2  0=clear, 1=scroll up one row, 2=fill row, 3=reserved
- cmd_row  in  5  target row for op 2 (0..ROWS-1)
- cmd_char  in  8  fill character
- cmd_attr  in  8  fill attribute
- cpu_req  in  1  CPU-side access request (level)
- cpu_we  in  1  CPU write enable
- cpu_addr  in  AW  CPU cell address
- cpu_wchar, cpu_wattr  in  8 each  CPU write data
- cpu_gnt  out  1  combinational grant; CPU access occurs this cycle
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write strobe (char and attr together)
- ram_wchar, ram_wattr  out  8 each  RAM write data
- ram_rchar, ram_rattr  in  8 each  RAM read data, valid one cycle after the address
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes

## Operation
- Arbitration: CPU has fixed priority. `cpu_gnt = cpu_req` always. When cpu_req=1, the ram_* outputs mux the CPU signals and the engine stalls without advancing.
- Handshake: a command is accepted when cmd_valid & cmd_ready. op, row, char, and attr are latched on acceptance. cmd_ready = (state==IDLE).
- States: IDLE, CLEAR, SC_RD, SC_WR, FILL, DONE.
- CLEAR: writes {cmd_char, cmd_attr} to addresses 0..DEPTH-1 in ascending order, one per granted cycle. Goes to DONE after address DEPTH-1.
- Scroll (op 1): for a = 0..DEPTH-COLS-1:
  - SC_RD issues a read at a+COLS.
  - SC_WR writes the captured data to a.
  - After the last copy, enters FILL with the range DEPTH-COLS..DEPTH-1 and fills the bottom row with cmd_char/cmd_attr.
- Read capture: in the cycle immediately after a granted SC_RD, ram_rchar/ram_rattr are latched into a hold register unconditionally, even if the CPU owns the port that cycle. SC_WR then waits for a free cycle.
- Fill row (op 2): FILL covers cmd_row*COLS..cmd_row*COLS+COLS-1. If cmd_row ≥ ROWS, no writes occur and the engine goes to DONE.
- Op 3: accepted, no RAM access, goes straight to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Address arithmetic is AW bits wide. The cmd_row*COLS product is computed at acceptance and registered. The address counter never exceeds DEPTH-1.
- ram_we is asserted only for in-range addresses. The engine never reads or writes outside 0..DEPTH-1.

## Timing
- Reset values:
  - Outputs: cmd_ready=1, busy=0, done=0, ram_we=0, ram_addr=0, ram_wchar=0, ram_wattr=0.
  - cpu_gnt follows cpu_req combinationally.
  - State IDLE; hold and address registers 0.
- Accept at cycle 0, first engine RAM access at cycle 1. busy=1 from cycle 1 through the DONE cycle.
- Uncontended latencies, counted from acceptance to the done pulse:
  - Clear: DEPTH+1 cycles (2401).
  - Scroll: 2*(DEPTH-COLS)+COLS+1 cycles (4721).
  - Fill row: COLS+1 cycles (81).
  - Op 3 / bad row: 1 cycle.
- Each cycle of cpu_req during busy adds exactly one cycle of latency.
- cmd_valid while busy is ignored; it is not queued.
- rst_n assertion mid-command aborts immediately: IDLE, no further writes, no done pulse.

## Test plan
- Clear, char=0x20, attr=0x07, no CPU traffic -> 2400 writes at addresses 0..2399, all {0x20,0x07}; done at cycle 2401; model RAM fully matches.
- Scroll with row r preset to char r, char=0x20 -> rows 0..28 hold r+1, row 29 all 0x20; done at cycle 4721; no write to any address ≥2400.
- Scroll with random cpu_req bursts, including a request on the cycle right after each SC_RD -> final RAM equals the reference scroll plus the CPU writes; latency is 4721 plus the number of stall cycles.
- Fill row 5, char=0x41, attr=0x1F -> addresses 400..479 written; all others unchanged; done at cycle 81. Repeat with row 31 -> zero writes, done at cycle 1.
- cmd_valid held high during a clear -> second command is ignored until cmd_ready returns; op 3 -> done next cycle with no ram_we.
- rst_n pulsed at cycle 1000 of a clear -> ram_we=0 immediately; cmd_ready=1; addresses ≥ the abort point are untouched; no done pulse.

Source files
------------

// File: rtl/char_ram_sequencer_if.sv
// Bus bundle for the text-RAM clear/scroll engine: command handshake,
// CPU-side access port and the single CPU-side RAM port it arbitrates.
interface char_ram_sequencer_if #(
    parameter int AW = 12
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [4:0]    cmd_row;
    logic [7:0]    cmd_char;
    logic [7:0]    cmd_attr;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wchar;
    logic [7:0]    cpu_wattr;
    logic          cpu_gnt;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wchar;
    logic [7:0]    ram_wattr;
    logic [7:0]    ram_rchar;
    logic [7:0]    ram_rattr;

    logic          busy;
    logic          done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_row, cmd_char, cmd_attr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wchar, cpu_wattr,
        input  ram_rchar, ram_rattr,
        output cmd_ready, cpu_gnt,
        output ram_addr, ram_we, ram_wchar, ram_wattr,
        output busy, done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_row, cmd_char, cmd_attr,
        output cpu_req, cpu_we, cpu_addr, cpu_wchar, cpu_wattr,
        output ram_rchar, ram_rattr,
        input  cmd_ready, cpu_gnt,
        input  ram_addr, ram_we, ram_wchar, ram_wattr,
        input  busy, done
    );
endinterface

// File: rtl/char_ram_sequencer.sv
// Clear / scroll-up / fill-row engine for the 80x30 character+attribute RAM.
// Shares the RAM's CPU-side port with the CPU, which always wins arbitration.
module char_ram_sequencer #(
    parameter int COLS = 80,
    parameter int ROWS = 30,
    parameter int AW   = 12
) (
    input logic                  clk,
    input logic                  rst_n,
    char_ram_sequencer_if.slave  bus
);
    localparam int DEPTH = COLS * ROWS;

    localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);
    localparam logic [AW-1:0] SCROLL_LAST = AW'(DEPTH - COLS - 1);
    localparam logic [AW-1:0] BOTTOM_ROW  = AW'(DEPTH - COLS);
    localparam logic [AW-1:0] COLS_A      = AW'(COLS);
    localparam logic [AW-1:0] COLS_M1     = AW'(COLS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_SC_RD = 3'd2;
    localparam logic [2:0] S_SC_WR = 3'd3;
    localparam logic [2:0] S_FILL  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    state;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] end_q;
    logic [7:0]    char_q;
    logic [7:0]    attr_q;
    logic [7:0]    hold_char;
    logic [7:0]    hold_attr;
    logic          rd_pend;

    logic          stall;
    logic          accept;
    logic          row_ok;
    logic [AW-1:0] row_base;

    assign stall    = bus.cpu_req;
    assign accept   = bus.cmd_valid && (state == S_IDLE);
    assign row_ok   = (int'(bus.cmd_row) < ROWS);
    assign row_base = AW'(bus.cmd_row) * COLS_A;

    // NOTE: all state below updates with non-blocking assignments so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            end_q     <= '0;
            char_q    <= '0;
            attr_q    <= '0;
            hold_char <= '0;
            hold_attr <= '0;
            rd_pend   <= 1'b0;
        end else begin
            // Read data returns the cycle after a granted read; grab it even
            // if the CPU has taken the port, so the copy survives the stall.
            rd_pend <= (state == S_SC_RD) && !stall;
            if (rd_pend) begin
                hold_char <= bus.ram_rchar;
                hold_attr <= bus.ram_rattr;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        char_q <= bus.cmd_char;
                        attr_q <= bus.cmd_attr;
                        case (bus.cmd_op)
                            2'd0: begin
                                addr_q <= '0;
                                end_q  <= LAST_ADDR;
                                state  <= S_CLEAR;
                            end
                            2'd1: begin
                                addr_q <= '0;
                                end_q  <= SCROLL_LAST;
                                state  <= S_SC_RD;
                            end
                            2'd2: begin
                                if (row_ok) begin
                                    addr_q <= row_base;
                                    end_q  <= row_base + COLS_M1;
                                    state  <= S_FILL;
                                end else begin
                                    state  <= S_DONE;
                                end
                            end
                            default: state <= S_DONE;
                        endcase
                    end
                end
                S_CLEAR, S_FILL: begin
                    if (!stall) begin
                        if (addr_q == end_q) begin
                            state <= S_DONE;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                S_SC_RD: begin
                    if (!stall) begin
                        state <= S_SC_WR;
                    end
                end
                S_SC_WR: begin
                    if (!stall) begin
                        if (addr_q == end_q) begin
                            addr_q <= BOTTOM_ROW;
                            end_q  <= LAST_ADDR;
                            state  <= S_FILL;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                            state  <= S_SC_RD;
                        end
                    end
                end
                S_DONE: begin
                    if (!stall) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [AW-1:0] eng_addr;
    logic          eng_we;
    logic [7:0]    eng_wchar;
    logic [7:0]    eng_wattr;
    logic          addr_in_range;

    assign addr_in_range = (addr_q <= LAST_ADDR);

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        eng_addr  = addr_q;
        eng_we    = 1'b0;
        eng_wchar = char_q;
        eng_wattr = attr_q;
        case (state)
            S_CLEAR, S_FILL: eng_we = addr_in_range;
            S_SC_RD:         eng_addr = addr_q + COLS_A;
            S_SC_WR: begin
                eng_we    = addr_in_range;
                // First write attempt forwards the fresh read data directly.
                eng_wchar = rd_pend ? bus.ram_rchar : hold_char;
                eng_wattr = rd_pend ? bus.ram_rattr : hold_attr;
            end
            default: ;
        endcase
    end

    assign bus.cpu_gnt   = bus.cpu_req;
    assign bus.ram_addr  = stall ? bus.cpu_addr  : eng_addr;
    assign bus.ram_we    = stall ? bus.cpu_we    : eng_we;
    assign bus.ram_wchar = stall ? bus.cpu_wchar : eng_wchar;
    assign bus.ram_wattr = stall ? bus.cpu_wattr : eng_wattr;

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    // A stalled DONE cycle holds the pulse back so it stays one cycle wide.
    assign bus.done      = (state == S_DONE) && !stall;

endmodule

// File: tb/tb_char_ram_sequencer.sv
// Self-checking bench: RAM model on the CPU-side port plus a reference
// screen image computed from the clear/scroll/fill rules.
module tb_char_ram_sequencer;
    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int AW    = 12;
    localparam int DEPTH = COLS * ROWS;
    localparam int MSIZE = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    char_ram_sequencer_if #(.AW(AW)) bus ();

    char_ram_sequencer #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // RAM behind the port: synchronous write, read data one cycle later.
    logic [7:0] mem_c [MSIZE];
    logic [7:0] mem_a [MSIZE];
    int wr_cnt   = 0;
    int oob_cnt  = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        if (bus.ram_we) begin
            wr_cnt <= wr_cnt + 1;
            if (int'(bus.ram_addr) >= DEPTH) oob_cnt <= oob_cnt + 1;
            mem_c[bus.ram_addr] <= bus.ram_wchar;
            mem_a[bus.ram_addr] <= bus.ram_wattr;
        end else if (bus.busy && !bus.cpu_req && int'(bus.ram_addr) >= DEPTH) begin
            oob_cnt <= oob_cnt + 1;
        end
        bus.ram_rchar <= mem_c[bus.ram_addr];
        bus.ram_rattr <= mem_a[bus.ram_addr];
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    // Reference screen image.
    logic [7:0] exp_c [DEPTH];
    logic [7:0] exp_a [DEPTH];
    logic [7:0] pre_c [DEPTH];
    logic [7:0] pre_a [DEPTH];

    typedef struct {
        int         addr;
        logic [7:0] c;
        logic [7:0] a;
    } cpu_wr_t;
    cpu_wr_t cpu_wq[$];

    function automatic int count_mismatch(output int first);
        int cnt = 0;
        first = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_c[i] !== exp_c[i] || mem_a[i] !== exp_a[i]) begin
                if (first < 0) first = i;
                cnt++;
            end
        end
        return cnt;
    endfunction

    // Issue one command and run it to its done pulse; optionally contend
    // with CPU traffic (always right after an engine read, plus random bursts).
    task automatic run_cmd(input logic [1:0] op, input logic [4:0] row,
                           input logic [7:0] ch, input logic [7:0] at,
                           input bit contend, input bit hold_valid,
                           output int lat, output int stalls);
        bit prev_rd;
        int idle_seen;
        lat = -1;
        stalls = 0;
        prev_rd = 1'b0;
        idle_seen = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_row   = row;
        bus.cmd_char  = ch;
        bus.cmd_attr  = at;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        #1;
        tests_run++;
        if (bus.cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL accept_ready: cmd_ready=%b expected 1", bus.cmd_ready);
        end
        for (int n = 1; n <= 20000; n++) begin
            @(negedge clk);
            if (hold_valid) bus.cmd_op = 2'd3;
            else            bus.cmd_valid = 1'b0;
            bus.cpu_req = 1'b0;
            bus.cpu_we  = 1'b0;
            if (contend && (prev_rd || $urandom_range(7, 0) == 0)) begin
                bus.cpu_req = 1'b1;
                if (n > 400 && $urandom_range(1, 0) == 1) begin
                    cpu_wr_t w;
                    w.addr = $urandom_range(COLS - 1, 0);
                    w.c    = 8'($urandom_range(255, 0));
                    w.a    = 8'($urandom_range(255, 0));
                    bus.cpu_we    = 1'b1;
                    bus.cpu_addr  = AW'(w.addr);
                    bus.cpu_wchar = w.c;
                    bus.cpu_wattr = w.a;
                    cpu_wq.push_back(w);
                end else begin
                    bus.cpu_addr = AW'($urandom_range(DEPTH - 1, 0));
                end
            end
            #1;
            if (!bus.busy) idle_seen++;
            if (bus.cpu_req && bus.busy) stalls++;
            prev_rd = bus.busy && !bus.cpu_req && !bus.ram_we;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        tests_run++;
        if (idle_seen !== 0) begin
            tests_failed++;
            $display("FAIL busy_during_cmd: busy low in %0d cycles, expected 0", idle_seen);
        end
        if (!hold_valid && lat > 0) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL done_width: done=%b cmd_ready=%b expected 0/1",
                         bus.done, bus.cmd_ready);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.ram_we !== 1'b0 || bus.ram_addr !== '0 ||
            bus.ram_wchar !== 8'h00 || bus.ram_wattr !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs: ready=%b busy=%b done=%b we=%b addr=%0d wc=%h wa=%h expected 1 0 0 0 0 00 00",
                     bus.cmd_ready, bus.busy, bus.done, bus.ram_we, bus.ram_addr,
                     bus.ram_wchar, bus.ram_wattr);
        end
        bus.cpu_req = 1'b1;
        #1;
        tests_run++;
        if (bus.cpu_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL gnt_follows_req_hi: cpu_gnt=%b expected 1", bus.cpu_gnt);
        end
        bus.cpu_req = 1'b0;
        #1;
        tests_run++;
        if (bus.cpu_gnt !== 1'b0) begin
            tests_failed++;
            $display("FAIL gnt_follows_req_lo: cpu_gnt=%b expected 0", bus.cpu_gnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clear;
        int lat, st, w0, bad, first;
        w0 = wr_cnt;
        run_cmd(2'd0, 5'd0, 8'h20, 8'h07, 1'b0, 1'b0, lat, st);
        for (int i = 0; i < DEPTH; i++) begin
            exp_c[i] = 8'h20;
            exp_a[i] = 8'h07;
        end
        tests_run++;
        if (lat !== DEPTH + 1) begin
            tests_failed++;
            $display("FAIL clear_latency: got %0d expected %0d", lat, DEPTH + 1);
        end
        tests_run++;
        if (wr_cnt - w0 !== DEPTH) begin
            tests_failed++;
            $display("FAIL clear_writes: got %0d expected %0d", wr_cnt - w0, DEPTH);
        end
        bad = count_mismatch(first);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL clear_ram: %0d cells differ, first at %0d, expected 0", bad, first);
        end
    endtask

    task automatic test_scroll;
        int lat, st, w0, o0, bad, first, bad_lat;
        bad_lat = 0;
        for (int r = 0; r < ROWS; r++) begin
            logic [7:0] rc, ra;
            rc = 8'(r);
            ra = rc ^ 8'h80;
            run_cmd(2'd2, 5'(r), rc, ra, 1'b0, 1'b0, lat, st);
            if (lat != COLS + 1) bad_lat++;
            for (int c = 0; c < COLS; c++) begin
                exp_c[r * COLS + c] = rc;
                exp_a[r * COLS + c] = ra;
            end
        end
        tests_run++;
        if (bad_lat !== 0) begin
            tests_failed++;
            $display("FAIL preset_fill_latency: %0d rows off, expected 0", bad_lat);
        end
        bad = count_mismatch(first);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL preset_ram: %0d cells differ, first at %0d, expected 0", bad, first);
        end
        w0 = wr_cnt;
        o0 = oob_cnt;
        run_cmd(2'd1, 5'd0, 8'h20, 8'h07, 1'b0, 1'b0, lat, st);
        for (int i = 0; i < DEPTH; i++) begin
            if (i < DEPTH - COLS) begin
                exp_c[i] = exp_c[i + COLS];
                exp_a[i] = exp_a[i + COLS];
            end else begin
                exp_c[i] = 8'h20;
                exp_a[i] = 8'h07;
            end
        end
        tests_run++;
        if (lat !== 2 * (DEPTH - COLS) + COLS + 1) begin
            tests_failed++;
            $display("FAIL scroll_latency: got %0d expected %0d", lat, 2 * (DEPTH - COLS) + COLS + 1);
        end
        tests_run++;
        if (wr_cnt - w0 !== DEPTH || oob_cnt - o0 !== 0) begin
            tests_failed++;
            $display("FAIL scroll_writes: writes=%0d oob=%0d expected %0d/0",
                     wr_cnt - w0, oob_cnt - o0, DEPTH);
        end
        bad = count_mismatch(first);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL scroll_ram: %0d cells differ, first at %0d, expected 0", bad, first);
        end
    endtask

    task automatic test_fill_row;
        int lat, st, w0, bad, first;
        w0 = wr_cnt;
        run_cmd(2'd2, 5'd5, 8'h41, 8'h1F, 1'b0, 1'b0, lat, st);
        for (int i = 5 * COLS; i < 6 * COLS; i++) begin
            exp_c[i] = 8'h41;
            exp_a[i] = 8'h1F;
        end
        tests_run++;
        if (lat !== COLS + 1 || wr_cnt - w0 !== COLS) begin
            tests_failed++;
            $display("FAIL fill_row5: latency=%0d writes=%0d expected %0d/%0d",
                     lat, wr_cnt - w0, COLS + 1, COLS);
        end
        bad = count_mismatch(first);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL fill_row5_ram: %0d cells differ, first at %0d, expected 0", bad, first);
        end
    endtask

    task automatic test_bad_row;
        int lat, st, w0, bad, first;
        w0 = wr_cnt;
        run_cmd(2'd2, 5'd31, 8'h42, 8'h2F, 1'b0, 1'b0, lat, st);
        tests_run++;
        if (lat !== 1 || wr_cnt - w0 !== 0) begin
            tests_failed++;
            $display("FAIL fill_row31: latency=%0d writes=%0d expected 1/0", lat, wr_cnt - w0);
        end
        bad = count_mismatch(first);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL fill_row31_ram: %0d cells differ, first at %0d, expected 0", bad, first);
        end
    endtask

    task automatic test_op3;
        int lat, st, w0;
        w0 = wr_cnt;
        run_cmd(2'd3, 5'd0, 8'h00, 8'h00, 1'b0, 1'b0, lat, st);
        tests_run++;
        if (lat !== 1 || wr_cnt - w0 !== 0) begin
            tests_failed++;
            $display("FAIL op3: latency=%0d writes=%0d expected 1/0", lat, wr_cnt - w0);
        end
    endtask

    task automatic test_hold_valid;
        int lat, st, w0, extra, bad, first;
        bit we_seen;
        w0 = wr_cnt;
        extra = -1;
        we_seen = 1'b0;
        run_cmd(2'd0, 5'd0, 8'h2E, 8'h03, 1'b0, 1'b1, lat, st);
        for (int i = 0; i < DEPTH; i++) begin
            exp_c[i] = 8'h2E;
            exp_a[i] = 8'h03;
        end
        tests_run++;
        if (lat !== DEPTH + 1) begin
            tests_failed++;
            $display("FAIL hold_clear_latency: got %0d expected %0d", lat, DEPTH + 1);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k >= 2) bus.cmd_valid = 1'b0;
            #1;
            if (bus.ram_we) we_seen = 1'b1;
            if (bus.done && extra < 0) extra = k;
        end
        tests_run++;
        if (extra !== 2 || we_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL held_op3: done after %0d cycles we=%b expected 2/0", extra, we_seen);
        end
        tests_run++;
        if (wr_cnt - w0 !== DEPTH) begin
            tests_failed++;
            $display("FAIL hold_writes: got %0d expected %0d", wr_cnt - w0, DEPTH);
        end
        bad = count_mismatch(first);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL hold_ram: %0d cells differ, first at %0d, expected 0", bad, first);
        end
    endtask

    task automatic test_scroll_contention;
        int lat, st, o0, bad, first;
        logic [7:0] rd_exp_c;
        // Random screen written through the CPU side of the port.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            pre_c[i] = 8'($urandom_range(255, 0));
            pre_a[i] = 8'($urandom_range(255, 0));
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = 1'b1;
            bus.cpu_addr  = AW'(i);
            bus.cpu_wchar = pre_c[i];
            bus.cpu_wattr = pre_a[i];
            exp_c[i] = pre_c[i];
            exp_a[i] = pre_a[i];
        end
        @(negedge clk);
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = AW'(1234);
        rd_exp_c     = pre_c[1234];
        @(negedge clk);
        bus.cpu_req = 1'b0;
        #1;
        tests_run++;
        if (bus.ram_rchar !== rd_exp_c) begin
            tests_failed++;
            $display("FAIL cpu_read: got %h expected %h", bus.ram_rchar, rd_exp_c);
        end
        bad = count_mismatch(first);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL cpu_preset_ram: %0d cells differ, first at %0d, expected 0", bad, first);
        end
        cpu_wq.delete();
        o0 = oob_cnt;
        run_cmd(2'd1, 5'd0, 8'h5A, 8'hA5, 1'b1, 1'b0, lat, st);
        for (int i = 0; i < DEPTH; i++) begin
            exp_c[i] = (i < DEPTH - COLS) ? pre_c[i + COLS] : 8'h5A;
            exp_a[i] = (i < DEPTH - COLS) ? pre_a[i + COLS] : 8'hA5;
        end
        foreach (cpu_wq[k]) begin
            exp_c[cpu_wq[k].addr] = cpu_wq[k].c;
            exp_a[cpu_wq[k].addr] = cpu_wq[k].a;
        end
        tests_run++;
        if (lat !== 2 * (DEPTH - COLS) + COLS + 1 + st) begin
            tests_failed++;
            $display("FAIL contended_latency: got %0d expected %0d (stalls %0d)",
                     lat, 2 * (DEPTH - COLS) + COLS + 1 + st, st);
        end
        tests_run++;
        if (oob_cnt - o0 !== 0) begin
            tests_failed++;
            $display("FAIL contended_oob: got %0d expected 0", oob_cnt - o0);
        end
        bad = count_mismatch(first);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL contended_ram: %0d cells differ, first at %0d, expected 0", bad, first);
        end
    endtask

    task automatic test_abort;
        int lat, st, w0, d0, bad, first;
        run_cmd(2'd0, 5'd0, 8'h55, 8'h66, 1'b0, 1'b0, lat, st);
        w0 = wr_cnt;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd0;
        bus.cmd_char  = 8'h20;
        bus.cmd_attr  = 8'h07;
        for (int n = 1; n <= 1000; n++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
        end
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.ram_we !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_outputs: we=%b ready=%b busy=%b expected 0/1/0",
                     bus.ram_we, bus.cmd_ready, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            exp_c[i] = (i < 999) ? 8'h20 : 8'h55;
            exp_a[i] = (i < 999) ? 8'h07 : 8'h66;
        end
        tests_run++;
        if (done_cnt - d0 !== 0 || wr_cnt - w0 !== 999) begin
            tests_failed++;
            $display("FAIL abort_activity: done pulses=%0d writes=%0d expected 0/999",
                     done_cnt - d0, wr_cnt - w0);
        end
        bad = count_mismatch(first);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL abort_ram: %0d cells differ, first at %0d, expected 0", bad, first);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_row   = 5'd0;
        bus.cmd_char  = 8'h00;
        bus.cmd_attr  = 8'h00;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wchar = 8'h00;
        bus.cpu_wattr = 8'h00;

        test_reset;
        test_clear;
        test_scroll;
        test_fill_row;
        test_bad_row;
        test_op3;
        test_hold_valid;
        test_scroll_contention;
        test_abort;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
